// File: rtl/range_bit_scanner.sv
// range_bit_scanner: walks every set bit of a captured request vector that
// falls inside an inclusive index window [lo, hi], lowest first, handing out
// one index per valid/ready handshake, then pulses done with the accept count.
module range_bit_scanner #(
  parameter int N = 4
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       start,
  input  logic [N-1:0]               data,
  input  logic [$clog2(N)-1:0]       start_range,
  input  logic [$clog2(N)-1:0]       end_range,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(N)-1:0]       out_index,
  output logic                       done,
  output logic [$clog2(N+1)-1:0]     count
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    pending_q, pending_d;
  logic [IW-1:0]   lo_q, lo_d;
  logic [IW-1:0]   hi_q, hi_d;
  logic [CW-1:0]   count_q, count_d;

  // Candidate bits: still pending and inside the captured window. An inverted
  // window (lo > hi) naturally yields no candidates.
  logic [N-1:0]    hit;
  logic [N-1:0]    hit_lowest;
  logic            found;
  logic [IW-1:0]   found_idx;

  for (genvar gi = 0; gi < N; gi++) begin : g_hit
    assign hit[gi] = pending_q[gi] && (lo_q <= IW'(gi)) && (IW'(gi) <= hi_q);
  end

  // Lowest candidate: one-hot isolate for clearing, plus its encoded index.
  always_comb begin
    hit_lowest = hit & ~(hit - N'(1));
    found      = |hit;
    found_idx  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit[i]) begin
        found_idx = IW'(i);
      end
    end
  end

  // State and datapath registers; reset aborts any scan without a done pulse.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      count_q   <= count_d;
    end
  end

  // Next-state and outputs. Pending bits change only on accept, so out_index
  // is stable while out_valid waits for out_ready.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    count_d   = count_q;
    busy      = 1'b0;
    out_valid = 1'b0;
    out_index = '0;
    done      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pending_d = data;
          lo_d      = start_range;
          hi_d      = end_range;
          count_d   = '0;
          state_d   = S_SCAN;
        end
      end
      S_SCAN: begin
        busy = 1'b1;
        if (found) begin
          out_valid = 1'b1;
          out_index = found_idx;
          if (out_ready) begin
            pending_d = pending_q & ~hit_lowest;
            count_d   = count_q + CW'(1);
          end
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign count = count_q;

endmodule
